// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package pipe_ctrl_pkg;

    localparam int          REG_ADDR_W   = 5;
    localparam logic [4:0]  REG_X0       = 5'd0;
    localparam int          CTRL_STATE_W = 2;

    typedef enum logic [CTRL_STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_MDU_WAIT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator between ID and EX
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  hazard
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hardwired zero, so a load targeting it never produces a dependency
    assign rs1_match = (ex_rd == id_rs1);
    assign rs2_match = id_uses_rs2 && (ex_rd == id_rs2);
    assign hazard    = ex_mem_read && (ex_rd != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// rtl/pipe_hazard_sequencer.sv - stall/flush sequencer for the 5-stage pipeline; optional perf counters under PIPE_PERF_CNT_EN
module pipe_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_EXTRA = 1,
    parameter int CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    jal,
    input  logic                    jalr,
    input  logic                    branch_taken,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic                    id_uses_rs2,
    input  logic [REG_ADDR_W-1:0]   ex_rd,
    input  logic                    ex_mem_read,
    input  logic                    ex_mdu_start,
    input  logic                    mdu_done,
    input  logic                    mem_stall,
    output logic                    pc_write,
    output logic                    if_id_write,
    output logic                    id_ex_write,
    output logic                    ex_mem_write,
    output logic                    if_flush,
    output logic                    id_flush,
    output logic                    idex_bubble,
    output logic                    exmem_bubble,
    output logic [CTRL_STATE_W-1:0] ctrl_state,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_cycles
);

    localparam int RCNT_W = (REDIRECT_EXTRA > 1) ? $clog2(REDIRECT_EXTRA) : 1;
    localparam logic [RCNT_W-1:0] RELOAD =
        (REDIRECT_EXTRA > 0) ? RCNT_W'(REDIRECT_EXTRA - 1) : '0;

    ctrl_state_e       state;
    ctrl_state_e       state_next;
    logic [RCNT_W-1:0] cnt;
    logic [RCNT_W-1:0] cnt_next;
    logic              redir;
    logic              load_use;

    assign redir      = jal | jalr | branch_taken;
    assign ctrl_state = state;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard      (load_use)
    );

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        state_next   = state;
        cnt_next     = cnt;

        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_flush     = 1'b1;
            id_flush     = 1'b1;
        end else if (mem_stall) begin
            // Whole pipe freezes; pending redirect/MDU work resumes afterwards
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (redir) begin
                        if_flush = 1'b1;
                        id_flush = 1'b1;
                        if (REDIRECT_EXTRA > 0) begin
                            state_next = ST_REDIRECT;
                            cnt_next   = RELOAD;
                        end
                    end else if (ex_mdu_start) begin
                        if (!mdu_done) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_write  = 1'b0;
                            exmem_bubble = 1'b1;
                            state_next   = ST_MDU_WAIT;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    // Shadow flush while the imem returns wrong-path fetches
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    if (cnt == '0) begin
                        state_next = ST_RUN;
                    end else begin
                        cnt_next = cnt - RCNT_W'(1);
                    end
                end
                ST_MDU_WAIT: begin
                    if (mdu_done) begin
                        state_next = ST_RUN;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (if_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_cycles = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// tb/tb_pipe_hazard_sequencer.sv - randomized self-checking bench with behavioural model for pipe_hazard_sequencer
module tb_pipe_hazard_sequencer;

    localparam int EXTRA = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          jal, jalr, branch_taken;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs2, ex_mem_read, ex_mdu_start, mdu_done, mem_stall;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          if_flush, id_flush, idex_bubble, exmem_bubble;
    logic [1:0]    ctrl_state;
    logic [CW-1:0] stall_cycles, flush_cycles;

    int errors = 0;
    int checks = 0;

    // Behavioural model: remaining flush cycles, MDU busy flag, counter totals
    int flush_left = 0;
    bit busy       = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    always #5 clk = ~clk;

    pipe_hazard_sequencer #(.REDIRECT_EXTRA(EXTRA), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .jal          (jal),
        .jalr         (jalr),
        .branch_taken (branch_taken),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_mdu_start (ex_mdu_start),
        .mdu_done     (mdu_done),
        .mem_stall    (mem_stall),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .ex_mem_write (ex_mem_write),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .idex_bubble  (idex_bubble),
        .exmem_bubble (exmem_bubble),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        jal = 0; jalr = 0; branch_taken = 0;
        id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0;
        ex_mem_read = 0; ex_mdu_start = 0; mdu_done = 0; mem_stall = 0;
    endtask

    // Called at the falling edge with inputs already applied
    task automatic step(input string tag);
        logic [7:0] exp_o;
        logic [1:0] exp_st;
        bit         redir, lu;
        #1;
        redir  = jal | jalr | branch_taken;
        lu     = ex_mem_read && (ex_rd != 0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
        exp_st = (flush_left > 0) ? 2'd1 : (busy ? 2'd2 : 2'd0);
        // {pc, if_id, id_ex, ex_mem, if_flush, id_flush, idex_bubble, exmem_bubble}
        exp_o  = 8'b1111_0000;
        if (!rst_n)                 exp_o = 8'b0000_1100;
        else if (mem_stall)         exp_o = 8'b0000_0000;
        else if (flush_left > 0)    exp_o = 8'b1111_1100;
        else if (busy) begin
            if (!mdu_done)          exp_o = 8'b0001_0001;
        end
        else if (redir)             exp_o = 8'b1111_1100;
        else if (ex_mdu_start) begin
            if (!mdu_done)          exp_o = 8'b0001_0001;
        end
        else if (lu)                exp_o = 8'b0011_0010;

        check({tag, ".outs"}, {24'd0, pc_write, if_id_write, id_ex_write, ex_mem_write,
                               if_flush, id_flush, idex_bubble, exmem_bubble}, {24'd0, exp_o});
        check({tag, ".state"}, {30'd0, ctrl_state}, {30'd0, exp_st});

        @(posedge clk);
        if (!rst_n) begin
            flush_left = 0; busy = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_o[7] && m_stall < CMAX) m_stall++;
            if (exp_o[3] && m_flush < CMAX) m_flush++;
            if (!mem_stall) begin
                if (flush_left > 0)               flush_left--;
                else if (busy)                    busy = !mdu_done;
                else if (redir)                   flush_left = EXTRA;
                else if (ex_mdu_start && !mdu_done) busy = 1;
            end
        end
        #1;
`ifdef PIPE_PERF_CNT_EN
        check({tag, ".stall_cnt"}, 32'(stall_cycles), 32'(m_stall));
        check({tag, ".flush_cnt"}, 32'(flush_cycles), 32'(m_flush));
`else
        check({tag, ".stall_cnt"}, 32'(stall_cycles), 32'd0);
        check({tag, ".flush_cnt"}, 32'(flush_cycles), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset");

        rst_n = 1;
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
        step("lu");
        clear_in();
        step("lu_after");
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
        step("lu_x0");

        clear_in(); branch_taken = 1;
        step("br0");
        clear_in();
        step("br1"); step("br2"); step("br3");

        jalr = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
        step("jalr_pri");
        clear_in();
        step("jalr1"); step("jalr2"); step("jalr3");

        ex_mdu_start = 1;
        step("mdu0");
        clear_in();
        step("mdu1"); step("mdu2"); step("mdu3");
        mdu_done = 1;
        step("mdu_done");
        clear_in();
        step("mdu_after");
        ex_mdu_start = 1; mdu_done = 1;
        step("mdu_same");
        clear_in();
        step("mdu_same_after");

        ex_mdu_start = 1;
        step("frz_start");
        clear_in(); mem_stall = 1; mdu_done = 1;
        step("frz0"); step("frz1"); step("frz2");
        mem_stall = 0;
        step("frz_rel");
        clear_in();
        step("frz_after");

        jal = 1;
        step("rr_jal");
        clear_in();
        step("rr_redir");
        rst_n = 0;
        step("rr_reset");
        rst_n = 1;
        step("rr_run");

        for (int i = 0; i < 600; i++) begin
            clear_in();
            rst_n     = ($urandom_range(0, 49) != 0);
            mem_stall = ($urandom_range(0, 5) == 0);
            mdu_done  = ($urandom_range(0, 2) == 0);
            if (flush_left == 0 && !busy) begin
                jal          = ($urandom_range(0, 19) == 0);
                jalr         = ($urandom_range(0, 19) == 0);
                branch_taken = ($urandom_range(0, 14) == 0);
                ex_mdu_start = ($urandom_range(0, 7) == 0);
                ex_mem_read  = $urandom_range(0, 1);
                ex_rd        = 5'($urandom_range(0, 7));
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_uses_rs2  = $urandom_range(0, 1);
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
